// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front end. Samples the asynchronous rx line,
// deserialises 8N1 frames LSB-first and queues decoded bytes in a small FIFO
// that the core drains through uart_empty / uart_rdreq / uart_in.
// Optional build macro UART_RX_PARITY_EN: frames become 8E1, a PARITY state is
// inserted before STOP, and a parity_err pulse output is added.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       uart_rdreq,
    output logic [7:0] uart_in,
    output logic       uart_empty,
    output logic       frame_err,
    output logic       overflow
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Receiver state
    logic [1:0]       sync_q;
    logic             rx_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             cnt_exp;

    // Receiver outputs
    logic             push;
    logic             frame_err_d, frame_err_q;
    logic             parity_ok;
    logic             parity_err_d, parity_err_q;

    // FIFO state
    logic [7:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]  count_q, count_d;
    logic             empty_q, overflow_q;
    logic [7:0]       uart_in_q;
    logic             full, pop, wr_en;

    // Two-flop synchroniser; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx};
    end
    assign rx_s    = sync_q[1];
    assign cnt_exp = (cnt_q == '0);

    // Receive FSM state and bit-timing registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    // Next-state logic: half-bit delay into START centres every later sample
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (!cnt_exp) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rx_s) begin
                    state_d   = S_DATA;
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = S_IDLE;   // start bit did not hold: glitch
                end
            end
            S_DATA: begin
                if (!cnt_exp) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!cnt_exp) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    par_d   = rx_s;
                    cnt_d   = FULL_LOAD;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!cnt_exp) cnt_d = cnt_q - CNT_W'(1);
                else          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: push or flag an error on the stop-bit sample
    always_comb begin
`ifdef UART_RX_PARITY_EN
        parity_ok = ~^{shift_q, par_q};
`else
        parity_ok = 1'b1;
`endif
        push         = (state_q == S_STOP) && cnt_exp && rx_s && parity_ok;
        frame_err_d  = (state_q == S_STOP) && cnt_exp && !rx_s;
        parity_err_d = (state_q == S_STOP) && cnt_exp && !parity_ok;
    end

    // Error pulses are registered so they last exactly one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // FIFO control: a pop while full frees the slot the concurrent push takes
    always_comb begin
        full    = (count_q == DEPTH_CNT);
        pop     = uart_rdreq && !empty_q;
        wr_en   = push && (!full || pop);
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
        else if (!wr_en && pop) count_d = count_q - (ADDR_W + 1)'(1);
    end

    // FIFO pointers, count, flags and registered read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            uart_in_q  <= 8'h00;
        end else begin
            count_q <= count_d;
            empty_q <= (count_d == '0);
            if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
                uart_in_q <= mem_q[rd_ptr_q];
            end
            if (push && !wr_en) overflow_q <= 1'b1;
        end
    end

    // Storage array, no reset so it maps to RAM
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign uart_in    = uart_in_q;
    assign uart_empty = empty_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames with hand-computed expected bytes; each read
// request pushes its expected byte into a queue that a monitor drains.
module tb_uart_rx_fifo;

    localparam int CPB = 16;
    localparam int AW  = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PUSH_NEG = 171;
`else
    localparam int PUSH_NEG = 155;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       uart_rdreq = 1'b0;
    logic [7:0] uart_in;
    logic       uart_empty;
    logic       frame_err;
    logic       overflow;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         checks = 0;
    int         errors = 0;
    int         fe_cycles = 0;
    int         fe_before;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .uart_rdreq (uart_rdreq),
        .uart_in    (uart_in),
        .uart_empty (uart_empty),
        .frame_err  (frame_err),
        .overflow   (overflow)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #10 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endfunction

    // Read monitor: every requested read is compared one cycle later
    always @(posedge clk) begin
        if (uart_rdreq && rst_n) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got 0x%0h, required no read", uart_in);
            end else begin
                check("read_data", int'(uart_in), int'(exp_q.pop_front()));
            end
        end
    end

    // Count frame_err high cycles
    always @(negedge clk) begin
        if (frame_err) fe_cycles++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^d;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_b;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Called on a negedge; holds rdreq for exactly one rising edge
    task automatic do_read(input logic [7:0] exp);
        exp_q.push_back(exp);
        uart_rdreq = 1'b1;
        @(negedge clk);
        uart_rdreq = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", int'(uart_empty), 1);
        check("rst_uart_in", int'(uart_in), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte
        send_frame(8'hA5, 1'b1);
        check("a5_not_empty", int'(uart_empty), 0);
        do_read(8'hA5);
        check("a5_empty_after_pop", int'(uart_empty), 1);

        // Glitch: short low pulse is rejected, receiver still works afterwards
        fe_before = fe_cycles;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_empty", int'(uart_empty), 1);
        check("glitch_no_frame_err", fe_cycles - fe_before, 0);
        send_frame(8'h5A, 1'b1);
        do_read(8'h5A);

        // Framing error
        fe_before = fe_cycles;
        send_frame(8'h3C, 1'b0);
        repeat (30) @(negedge clk);
        check("fe_pulse_cycles", fe_cycles - fe_before, 1);
        check("fe_empty", int'(uart_empty), 1);

        // Overflow and wrap
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        check("ovf_set", int'(overflow), 1);
        for (int b = 1; b <= 4; b++) do_read(8'(b));
        check("ovf_drained_empty", int'(uart_empty), 1);
        do_read(8'h04);
        check("ovf_sticky", int'(overflow), 1);

        // Concurrent push and pop while full
        do_reset();
        check("cc_rst_overflow", int'(overflow), 0);
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
        check("cc_full_no_ovf", int'(overflow), 0);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (PUSH_NEG) @(negedge clk);
                do_read(8'h01);
            end
        join
        check("cc_no_overflow", int'(overflow), 0);
        do_read(8'h02);
        do_read(8'h03);
        do_read(8'h04);
        do_read(8'h55);
        check("cc_empty", int'(uart_empty), 1);

        // Reset during DATA bit 3
        fe_before = fe_cycles;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (73) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        check("midrst_empty", int'(uart_empty), 1);
        check("midrst_no_frame_err", fe_cycles - fe_before, 0);
        send_frame(8'h12, 1'b1);
        check("midrst_next_not_empty", int'(uart_empty), 0);
        do_read(8'h12);
        check("midrst_next_empty", int'(uart_empty), 1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end for the CPU core's UART byte interface.
- Samples the asynchronous rx pin and deserialises 8N1 frames; decoded bytes go into a small FIFO.
- Presents the FIFO to the core as uart_empty / uart_in / uart_rdreq, directly upstream of the core's UART read path.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W bytes.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- rx  input  1  asynchronous serial line; idle high.
- uart_rdreq  input  1  core pops one byte this cycle.
- uart_in  output  8  popped byte, registered.
- uart_empty  output  1  FIFO holds no bytes.
- frame_err  output  1  one-cycle pulse when a stop bit samples low.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low at a clk edge):
  - uart_in=0, uart_empty=1, frame_err=0, overflow=0.
  - FIFO pointers and count cleared; receive FSM in IDLE.
  - Synchroniser flops set to 1.
  - Reset mid-frame discards the partial byte; no pulse or push results.
- Synchroniser: rx passes through 2 flops to give rx_s. All FSM decisions use rx_s.
- Receive FSM, states IDLE, START, DATA, STOP:
  - IDLE: on rx_s=0, load bit counter with CLKS_PER_BIT/2-1 and go to START.
  - START: when the counter reaches 0, sample rx_s.
    - 0: reload the counter with CLKS_PER_BIT-1, set bit_idx=0, go to DATA.
    - 1: glitch; return to IDLE.
  - DATA: at each counter expiry, shift rx_s into shift_reg LSB-first (bit_idx 0 = LSB) and reload the counter. After bit_idx 7, go to STOP.
  - STOP: at counter expiry, sample rx_s.
    - 1: push shift_reg into the FIFO.
    - 0: pulse frame_err for 1 cycle; no push.
    - Either way, return to IDLE the same cycle.
- Counter widths must hold CLKS_PER_BIT-1 without overflow.
- FIFO:
  - Circular buffer with ADDR_W-bit read/write pointers that wrap modulo depth.
  - Count register of ADDR_W+1 bits.
  - Full when count == depth.
- Push while full: byte discarded, overflow set to 1. overflow stays set until reset.
- Pop:
  - uart_rdreq=1 with uart_empty=0: uart_in takes mem[rd_ptr] on the next edge, rd_ptr increments, count decrements.
  - Read latency is 1 cycle: the byte is valid the cycle after rdreq.
- uart_rdreq while uart_empty=1: ignored. uart_in holds its value; pointers are unchanged.
- Simultaneous push and pop:
  - Count unchanged, both pointers advance.
  - This is legal when full: the pop frees the slot, the push is accepted, and overflow is not set.
  - Push into an empty FIFO with a pop in the same cycle: the pop is ignored because uart_empty was 1. The byte becomes visible next cycle.
- uart_empty is registered. It deasserts the cycle after the push edge.
- uart_in changes only on an accepted pop.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP and samples one bit.
  - If XOR(data, parity bit) != 0, the byte is not pushed and output parity_err pulses 1 cycle at the STOP sample.
  - parity_err is 0 after reset.
  - A frame with both a parity error and a framing error pulses both outputs.
- Undefined: 8N1, no PARITY state, parity_err port absent.

Test Plan (CLKS_PER_BIT=16, ADDR_W=2, 20 ns clk):
- Reset: hold rst_n=0 for 3 cycles, rx=1 -> uart_empty=1, uart_in=0x00, overflow=0, frame_err=0.
- Single byte: drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> uart_empty falls after the stop sample. Pulse uart_rdreq 1 cycle -> next cycle uart_in=0xA5 and uart_empty=1.
- Glitch and framing:
  - rx low for 4 cycles then high -> no push, FSM back in IDLE.
  - Frame 0x3C with stop=0 -> frame_err pulses exactly 1 cycle, uart_empty stays 1.
- Overflow and wrap: send 0x01..0x05 with no reads -> overflow=1 after the 5th frame. Reads return 0x01,0x02,0x03,0x04, then uart_empty=1. Further rdreq leaves uart_in=0x04.
- Concurrent push/pop at full: fill with 4 bytes, then assert uart_rdreq in the exact cycle the 5th frame (0x55) pushes -> overflow stays 0. Subsequent reads return 0x02,0x03,0x04,0x55.
- Reset mid-frame: assert rst_n=0 for 1 cycle during DATA bit 3 of frame 0xFF, then idle -> uart_empty stays 1. The next frame 0x12 is received correctly.
